// File: rtl/temp_sampler.sv
// Two-channel temperature sampler: 4-sample moving averages, outside-vs-greenhouse flag, staleness watchdog.
// Optional spike rejection on warm channels is compiled in with TEMP_SAMPLER_SPIKE_REJECT_EN.
module temp_sampler #(
  parameter logic [15:0] STALE_LIMIT = 16'd1000,
  parameter logic [7:0]  SPIKE_DELTA = 8'd20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic              sample_sel,
  input  logic signed [7:0] sample_data,
  output logic signed [7:0] greenhouse_temp,
  output logic signed [7:0] outside_temp,
  output logic              temp_g_greenhouse_temp,
  output logic              temp_valid,
  output logic [1:0]        stale,
  output logic [7:0]        spike_cnt
);

`ifdef TEMP_SAMPLER_SPIKE_REJECT_EN
  localparam logic SPIKE_EN = 1'b1;
`else
  localparam logic SPIKE_EN = 1'b0;
`endif

  // channel index 0 = greenhouse, 1 = outside
  logic signed [7:0] r_win [2][4];
  logic [1:0]        r_ptr [2];
  logic signed [9:0] r_sum [2];
  logic [2:0]        r_warm [2];
  logic [15:0]       r_idle [2];
  logic signed [7:0] r_avg [2];
  logic [1:0]        r_stale;
  logic [1:0]        r_upd;
  logic              r_flag;
  logic              r_valid;
  logic [7:0]        r_spike_cnt;

  logic signed [7:0] w_avg_now [2];
  logic signed [8:0] w_diff [2];
  logic [8:0]        w_abs [2];
  logic signed [9:0] w_sum_next [2];
  logic [15:0]       w_idle_inc [2];
  logic [1:0]        w_warm;
  logic [1:0]        w_hit;
  logic [1:0]        w_reject;
  logic [1:0]        w_accept;
  logic [1:0]        w_stale_set;
  logic signed [7:0] w_gh_next;
  logic signed [7:0] w_out_next;

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      // sum[9:2] is the arithmetic shift by 2, i.e. floor(sum/4)
      w_avg_now[ch]  = r_sum[ch][9:2];
      w_diff[ch]     = {sample_data[7], sample_data} - {w_avg_now[ch][7], w_avg_now[ch]};
      w_abs[ch]      = w_diff[ch][8] ? (~w_diff[ch] + 9'd1) : w_diff[ch];
      w_warm[ch]     = (r_warm[ch] == 3'd4);
      w_hit[ch]      = sample_valid && (sample_sel == ch[0]);
      w_reject[ch]   = SPIKE_EN && w_hit[ch] && w_warm[ch] && (w_abs[ch] > {1'b0, SPIKE_DELTA});
      w_accept[ch]   = w_hit[ch] && !w_reject[ch];
      w_sum_next[ch] = r_sum[ch]
                       - {{2{r_win[ch][r_ptr[ch]][7]}}, r_win[ch][r_ptr[ch]]}
                       + {{2{sample_data[7]}}, sample_data};
      w_idle_inc[ch] = r_idle[ch] + 16'd1;
      // an acceptance on the limit edge wins over going stale
      w_stale_set[ch] = !w_accept[ch] && (r_idle[ch] != STALE_LIMIT)
                        && (w_idle_inc[ch] == STALE_LIMIT);
    end
    w_gh_next  = r_upd[0] ? w_avg_now[0] : r_avg[0];
    w_out_next = r_upd[1] ? w_avg_now[1] : r_avg[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        for (int i = 0; i < 4; i++) r_win[ch][i] <= '0;
        r_ptr[ch]  <= '0;
        r_sum[ch]  <= '0;
        r_warm[ch] <= '0;
        r_idle[ch] <= '0;
        r_avg[ch]  <= '0;
      end
      r_stale     <= '0;
      r_upd       <= '0;
      r_flag      <= 1'b0;
      r_valid     <= 1'b0;
      r_spike_cnt <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (w_accept[ch]) begin
          r_win[ch][r_ptr[ch]] <= sample_data;
          r_ptr[ch]            <= r_ptr[ch] + 2'd1;
          r_sum[ch]            <= w_sum_next[ch];
          if (!w_warm[ch]) r_warm[ch] <= r_warm[ch] + 3'd1;
          r_idle[ch]           <= '0;
          r_stale[ch]          <= 1'b0;
        end else if (w_stale_set[ch]) begin
          // stale data is worthless: restart warm-up from an empty window
          for (int i = 0; i < 4; i++) r_win[ch][i] <= '0;
          r_ptr[ch]   <= '0;
          r_sum[ch]   <= '0;
          r_warm[ch]  <= '0;
          r_idle[ch]  <= w_idle_inc[ch];
          r_stale[ch] <= 1'b1;
        end else if (r_idle[ch] != STALE_LIMIT) begin
          r_idle[ch] <= w_idle_inc[ch];
        end
        if (r_upd[ch]) r_avg[ch] <= w_avg_now[ch];
      end
      r_upd <= w_accept;
      if (|r_upd) begin
        if (w_out_next > w_gh_next)      r_flag <= 1'b1;
        else if (w_out_next < w_gh_next) r_flag <= 1'b0;
      end
      r_valid <= (&w_warm) && (r_stale == 2'b00);
      if ((|w_reject) && (r_spike_cnt != 8'hFF)) r_spike_cnt <= r_spike_cnt + 8'd1;
    end
  end

  assign greenhouse_temp        = r_avg[0];
  assign outside_temp           = r_avg[1];
  assign temp_g_greenhouse_temp = r_flag;
  assign temp_valid             = r_valid;
  assign stale                  = r_stale;
  assign spike_cnt              = r_spike_cnt;

endmodule

// File: tb/tb_temp_sampler.sv
// Self-checking bench for temp_sampler; expected averages come from a shift-register window model
// and flow through a scoreboard queue. Honours TEMP_SAMPLER_SPIKE_REJECT_EN when defined.
module tb_temp_sampler;
  localparam int STALE_LIM = 100;
  localparam int DELTA     = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_valid;
  logic              sample_sel;
  logic signed [7:0] sample_data;
  logic signed [7:0] greenhouse_temp;
  logic signed [7:0] outside_temp;
  logic              temp_g_greenhouse_temp;
  logic              temp_valid;
  logic [1:0]        stale;
  logic [7:0]        spike_cnt;

  temp_sampler #(.STALE_LIMIT(16'(STALE_LIM)), .SPIKE_DELTA(8'(DELTA))) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_sel(sample_sel),
    .sample_data(sample_data), .greenhouse_temp(greenhouse_temp), .outside_temp(outside_temp),
    .temp_g_greenhouse_temp(temp_g_greenhouse_temp), .temp_valid(temp_valid),
    .stale(stale), .spike_cnt(spike_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int avg; } sb_t;
  sb_t sb[$];

  int win [2][4];
  int exp_avg [2];
  int warm [2];
  bit stale_m [2];
  bit exp_flag;
  int spikes;
  int n_cmp = 0;
  int n_err = 0;

  function automatic int fdiv4(int s);
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  function automatic int wsum(int ch);
    int s = 0;
    for (int i = 0; i < 4; i++) s += win[ch][i];
    return s;
  endfunction

  function automatic logic [27:0] exp_vec();
    logic v;
    v = (warm[0] >= 4) && (warm[1] >= 4) && !stale_m[0] && !stale_m[1];
    return {8'(exp_avg[0]), 8'(exp_avg[1]), exp_flag, v, stale_m[1], stale_m[0], 8'(spikes)};
  endfunction

  function automatic logic [27:0] dut_vec();
    return {greenhouse_temp, outside_temp, temp_g_greenhouse_temp, temp_valid, stale, spike_cnt};
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      for (int i = 0; i < 4; i++) win[ch][i] = 0;
      exp_avg[ch] = 0;
      warm[ch]    = 0;
      stale_m[ch] = 1'b0;
    end
    exp_flag = 1'b0;
    spikes   = 0;
    sb.delete();
  endtask

  task automatic model_stale(int ch);
    for (int i = 0; i < 4; i++) win[ch][i] = 0;
    warm[ch]    = 0;
    stale_m[ch] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_valid = 1'b1; sample_sel = 1'b0; sample_data = 8'sd77;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; sample_valid = 1'b0;
    model_reset();
  endtask

  // drive one sample for one cycle; model decides acceptance and queues the expected average
  task automatic send(int ch, int d);
    int diff;
    bit acc;
    sample_valid = 1'b1; sample_sel = (ch != 0); sample_data = 8'(d);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    acc  = 1'b1;
    diff = d - fdiv4(wsum(ch));
    if (diff < 0) diff = -diff;
`ifdef TEMP_SAMPLER_SPIKE_REJECT_EN
    if (warm[ch] >= 4 && diff > DELTA) begin
      acc = 1'b0;
      if (spikes < 255) spikes++;
    end
`else
    if (diff < 0) acc = 1'b0;
`endif
    if (acc) begin
      for (int i = 0; i < 3; i++) win[ch][i] = win[ch][i+1];
      win[ch][3] = d;
      if (warm[ch] < 4) warm[ch]++;
      stale_m[ch] = 1'b0;
      sb.push_back('{ch, fdiv4(wsum(ch))});
    end
  endtask

  task automatic drain();
    sb_t e;
    bit upd = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      exp_avg[e.ch] = e.avg;
      upd = 1'b1;
    end
    if (upd) begin
      if (exp_avg[1] > exp_avg[0])      exp_flag = 1'b1;
      else if (exp_avg[1] < exp_avg[0]) exp_flag = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset_state got %h exp %h", dut_vec(), exp_vec());
    end
    @(posedge clk); #1;
    n_cmp++;
    if (dut_vec() !== 28'h0) begin
      n_err++; $display("FAIL reset_idle got %h exp %h", dut_vec(), 28'h0);
    end
  endtask

  task automatic test_warmup();
    int chs [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int vals[8] = '{20, 20, 20, 20, 30, 30, 30, 30};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(chs[i], vals[i]);
      @(posedge clk); #1; drain();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL warmup[%0d] got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (greenhouse_temp !== 8'sd20 || outside_temp !== 8'sd30 || temp_g_greenhouse_temp !== 1'b1 || temp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL warmup_final got gh=%0d out=%0d flag=%b valid=%b exp gh=20 out=30 flag=1 valid=1",
               greenhouse_temp, outside_temp, temp_g_greenhouse_temp, temp_valid);
    end
  endtask

  task automatic test_floor();
    int vals[8] = '{-3, -3, -3, -2, 127, 127, 127, 127};
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || i == 4) do_reset();
      send(0, vals[i]);
      @(posedge clk); #1; drain();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL floor[%0d] got %h exp %h", i, dut_vec(), exp_vec());
      end
      if (i == 3) begin
        n_cmp++;
        if (greenhouse_temp !== -8'sd3) begin
          n_err++; $display("FAIL floor_neg got %0d exp -3", greenhouse_temp);
        end
      end
    end
    n_cmp++;
    if (greenhouse_temp !== 8'sd127) begin
      n_err++; $display("FAIL floor_max got %0d exp 127", greenhouse_temp);
    end
  endtask

  task automatic test_flag();
    int chs [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int vals[13] = '{25, 25, 25, 25, 30, 30, 30, 30, 25, 25, 25, 25, 24};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      send(chs[i], vals[i]);
      @(posedge clk); #1; drain();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL flag[%0d] got %h exp %h", i, dut_vec(), exp_vec());
      end
      if (i == 11) begin
        n_cmp++;
        if (temp_g_greenhouse_temp !== 1'b1) begin
          n_err++; $display("FAIL flag_equal_hold got %b exp 1", temp_g_greenhouse_temp);
        end
      end
    end
    n_cmp++;
    if (temp_g_greenhouse_temp !== 1'b0 || outside_temp !== 8'sd24) begin
      n_err++; $display("FAIL flag_drop got flag=%b out=%0d exp flag=0 out=24", temp_g_greenhouse_temp, outside_temp);
    end
  endtask

  // outside warmed first, greenhouse last; leaves the bench 1ns after edge E+LIMIT-1
  // where E is the outside channel's last acceptance edge
  task automatic warm_both_to_limit(string tag);
    for (int i = 0; i < 8; i++) begin
      send(i < 4 ? 1 : 0, 10);
      @(posedge clk); #1; drain();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL %s_warm[%0d] got %h exp %h", tag, i, dut_vec(), exp_vec());
      end
    end
    repeat (STALE_LIM - 10) @(posedge clk);
    #1;
    n_cmp++;
    if (stale !== 2'b00) begin
      n_err++; $display("FAIL %s_early got %b exp 00", tag, stale);
    end
  endtask

  task automatic test_stale();
    int chs [5] = '{0, 1, 1, 1, 1};
    int vals[5] = '{10, 20, 20, 20, 20};
    do_reset();
    warm_both_to_limit("stale");
    @(posedge clk); #1;
    n_cmp++;
    if (stale !== 2'b10) begin
      n_err++; $display("FAIL stale_set got %b exp 10", stale);
    end
    model_stale(1);
    @(posedge clk); #1;
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL stale_state got %h exp %h", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 5; i++) begin
      send(chs[i], vals[i]);
      @(posedge clk); #1; drain();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL stale_recover[%0d] got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (temp_valid !== 1'b1 || stale !== 2'b00) begin
      n_err++; $display("FAIL stale_restored got valid=%b stale=%b exp valid=1 stale=00", temp_valid, stale);
    end
  endtask

  task automatic test_stale_priority();
    do_reset();
    warm_both_to_limit("prio");
    send(1, 10);
    @(posedge clk); #1; drain();
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL prio_edge got %h exp %h", dut_vec(), exp_vec());
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (stale !== 2'b00 || temp_valid !== 1'b1) begin
      n_err++; $display("FAIL prio_after got stale=%b valid=%b exp stale=00 valid=1", stale, temp_valid);
    end
  endtask

  task automatic test_spike();
    int vals[6] = '{20, 20, 20, 20, 41, 40};
    int exp_spk;
`ifdef TEMP_SAMPLER_SPIKE_REJECT_EN
    exp_spk = 1;
`else
    exp_spk = 0;
`endif
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(0, vals[i]);
      @(posedge clk); #1; drain();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL spike[%0d] got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (spike_cnt !== 8'(exp_spk)) begin
      n_err++; $display("FAIL spike_cnt got %0d exp %0d", spike_cnt, exp_spk);
    end
  endtask

  task automatic test_reset_mid();
    int chs [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    int vals[8] = '{40, 40, 40, 8, 8, 8, 8, 40};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send(0, 30);
      @(posedge clk); #1; drain();
    end
    rst = 1'b1; sample_valid = 1'b1; sample_sel = 1'b0; sample_data = 8'sd50;
    @(posedge clk); #1;
    rst = 1'b0; sample_valid = 1'b0;
    model_reset();
    n_cmp++;
    if (dut_vec() !== 28'h0) begin
      n_err++; $display("FAIL midreset_state got %h exp %h", dut_vec(), 28'h0);
    end
    for (int i = 0; i < 8; i++) begin
      send(chs[i], vals[i]);
      @(posedge clk); #1; drain();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL midreset[%0d] got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout reached got running exp finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample_sel = 1'b0; sample_data = '0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_warmup();
    test_floor();
    test_flag();
    test_stale();
    test_stale_priority();
    test_spike();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
